mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing one multiplier.
REQ-002 Parameter DATA_WIDTH, default 32, operand and result width.
REQ-003 Parameter TIMEOUT_CYCLES, default 64, WAIT-state watchdog limit; used only with MULT_ARB_TIMEOUT_EN.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  NUM_REQ  per-requester request; held high with stable operands until grant.
REQ-007 req_a  input  NUM_REQ x DATA_WIDTH  per-requester operand A.
REQ-008 req_b  input  NUM_REQ x DATA_WIDTH  per-requester operand B.
REQ-009 grant  output  NUM_REQ  one-hot, one-cycle pulse; operands captured this cycle.
REQ-010 resp_valid  output  NUM_REQ  one-hot, one-cycle pulse to the owner; resp_data valid.
REQ-011 resp_data  output  DATA_WIDTH  shared result bus.
REQ-012 mult_a, mult_b  output  DATA_WIDTH  multiplier operands, held from ISSUE until RESP.
REQ-013 mult_start  output  1  one-cycle multiplier start pulse.
REQ-014 mult_out  input  DATA_WIDTH  multiplier result.
REQ-015 mult_done  input  1  multiplier completion pulse.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 timeout_err  output  1  sticky watchdog error flag.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-019 IDLE: any req bit high -> winner chosen round-robin starting at rr_ptr; operands and owner registered; next state ISSUE.
REQ-020 ISSUE (exactly 1 cycle): grant[owner]=1, mult_start=1, mult_a/mult_b = captured operands; next state WAIT.
REQ-021 WAIT: mult_done=1 -> mult_out registered into resp_data; next state RESP; mult_done is ignored in all other states.
REQ-022 RESP (exactly 1 cycle): resp_valid[owner]=1; rr_ptr <= (owner+1) mod NUM_REQ; next state IDLE.
REQ-023 Latency: req sampled in IDLE at cycle N -> grant/mult_start at N+1; mult_done at cycle M -> resp_valid at M+1; back-to-back operations separated by one IDLE cycle.
REQ-024 req bits sampled only in IDLE; req still high during ISSUE/WAIT/RESP creates no extra grant.
REQ-025 Simultaneous requests: lowest index at or above rr_ptr wins, wrapping to 0; no requester starves.
REQ-026 resp_data holds its last value until the next RESP; grant and resp_valid never exceed one bit high.

Reset
REQ-027 rst high: state IDLE, rr_ptr 0, grant 0, resp_valid 0, resp_data 0, mult_a/mult_b 0, mult_start 0, busy 0, timeout_err 0, watchdog counter 0.
REQ-028 Reset mid-operation drops the in-flight operation: no resp_valid is produced for it, and a later stray mult_done is ignored in IDLE.

Configuration
REQ-029 With MULT_ARB_TIMEOUT_EN defined: a counter runs in WAIT; reaching TIMEOUT_CYCLES without mult_done sets timeout_err (sticky until rst), forces resp_data to 0, and moves to RESP.
REQ-030 Without MULT_ARB_TIMEOUT_EN: no counter logic; WAIT persists until mult_done; timeout_err tied to 0; port list unchanged.

Structure
REQ-031 Package mult_arb_pkg SHALL hold the FSM state enum and DATA_WIDTH/NUM_REQ default constants.
REQ-032 Sub-module rr_picker SHALL implement the combinational round-robin selection (req vector, rr_ptr -> one-hot winner, valid).

Verification
REQ-033 Single request: req[0] with a=3, b=5; multiplier done 4 cycles after start with mult_out=15 -> grant[0] 1 cycle after req, resp_valid[0] with resp_data=15.
REQ-034 Contention: req[0] and req[1] together from reset -> requester 0 served first, then 1; repeating the contention -> 1 served first.
REQ-035 Persistent req: req[1] held 20 cycles -> exactly one grant per completed operation, never in ISSUE/WAIT/RESP.
REQ-036 Reset in WAIT: rst pulse while busy, then mult_done -> no resp_valid; busy=0; next request from requester 0 served normally.
REQ-037 Timeout (macro on, TIMEOUT_CYCLES=8): mult_done never arrives -> timeout_err=1 after 8 WAIT cycles, resp_valid with resp_data=0; flag stays high until rst.
REQ-038 Macro off: same stimulus -> FSM stays in WAIT, timeout_err=0; late mult_done=7 -> resp_data=7.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// Shared types and defaults for the multiplier arbiter: FSM state encoding,
// default sizing constants and the index-width helper.
package mult_arb_pkg;

    localparam int DEFAULT_NUM_REQ    = 2;
    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    // Width of a requester index; a single requester still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selection: the first asserted request at or
// above rr_ptr (wrapping to 0) wins, reported as one-hot, index and valid.
module rr_picker
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner_oh,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               valid
);

    logic [NUM_REQ-1:0] hit;
    logic [IDX_W-1:0]   cand_idx [NUM_REQ];

    // Candidate gi is the requester gi positions after rr_ptr, modulo NUM_REQ.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum = {1'b0, rr_ptr} + (IDX_W+1)'(gi);
            assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQ))
                                ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                : sum[IDX_W-1:0];
            assign hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Scan from the farthest candidate down so the nearest hit is kept.
    always_comb begin
        valid      = 1'b0;
        winner_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                valid      = 1'b1;
                winner_idx = cand_idx[k];
            end
        end
        winner_oh = valid ? (NUM_REQ'(1) << winner_idx) : '0;
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one external multiplier between NUM_REQ requesters.
// Optional WAIT-state watchdog enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEFAULT_NUM_REQ,
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]                   grant,
    output logic [NUM_REQ-1:0]                   resp_valid,
    output logic [DATA_WIDTH-1:0]                resp_data,
    output logic [DATA_WIDTH-1:0]                mult_a,
    output logic [DATA_WIDTH-1:0]                mult_b,
    output logic                                 mult_start,
    input  logic [DATA_WIDTH-1:0]                mult_out,
    input  logic                                 mult_done,
    output logic                                 busy,
    output logic                                 timeout_err
);

    localparam int               IDX_W    = idx_width(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    arb_state_e            state_q,      state_d;
    logic [IDX_W-1:0]      owner_q,      owner_d;
    logic [IDX_W-1:0]      rr_ptr_q,     rr_ptr_d;
    logic [NUM_REQ-1:0]    grant_q,      grant_d;
    logic [NUM_REQ-1:0]    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_data_q,  resp_data_d;
    logic [DATA_WIDTH-1:0] mult_a_q,     mult_a_d;
    logic [DATA_WIDTH-1:0] mult_b_q,     mult_b_d;
    logic                  mult_start_q, mult_start_d;
    logic                  busy_q,       busy_d;

    logic [NUM_REQ-1:0]    pick_oh;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_valid;
    logic [NUM_REQ-1:0]    owner_oh;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int              WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_err_q, timeout_err_d;
`else
    // TIMEOUT_CYCLES has no effect without the watchdog.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (req),
        .rr_ptr     (rr_ptr_q),
        .winner_oh  (pick_oh),
        .winner_idx (pick_idx),
        .valid      (pick_valid)
    );

    assign owner_oh = NUM_REQ'(1) << owner_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = '0;
        resp_valid_d = '0;
        mult_start_d = 1'b0;
        mult_a_d     = mult_a_q;
        mult_b_d     = mult_b_q;
        resp_data_d  = resp_data_q;
`ifdef MULT_ARB_TIMEOUT_EN
        wd_cnt_d      = '0;
        timeout_err_d = timeout_err_q;
`endif
        unique case (state_q)
            // Requests are only looked at here, so a held req cannot re-grant mid-operation.
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d      = pick_idx;
                    mult_a_d     = req_a[pick_idx];
                    mult_b_d     = req_b[pick_idx];
                    grant_d      = pick_oh;
                    mult_start_d = 1'b1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mult_done) begin
                    resp_data_d  = mult_out;
                    resp_valid_d = owner_oh;
                    state_d      = ST_RESP;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (wd_cnt_q == WD_LIMIT) begin
                    timeout_err_d = 1'b1;
                    resp_data_d   = '0;
                    resp_valid_d  = owner_oh;
                    state_d       = ST_RESP;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
`endif
            end
            ST_RESP: begin
                rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
            mult_start_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            mult_a_q     <= mult_a_d;
            mult_b_q     <= mult_b_d;
            mult_start_q <= mult_start_d;
            busy_q       <= busy_d;
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign grant      = grant_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign mult_a     = mult_a_q;
    assign mult_b     = mult_b_q;
    assign mult_start = mult_start_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: the bench plays the multiplier and the
// requesters, and predicts winners from a round-robin pointer kept as an integer.
`timescale 1ns/1ps
module tb_mult_arbiter;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int TO = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req;
    logic [N-1:0][DW-1:0] req_a;
    logic [N-1:0][DW-1:0] req_b;
    logic [N-1:0]         grant;
    logic [N-1:0]         resp_valid;
    logic [DW-1:0]        resp_data;
    logic [DW-1:0]        mult_a;
    logic [DW-1:0]        mult_b;
    logic                 mult_start;
    logic [DW-1:0]        mult_out;
    logic                 mult_done;
    logic                 busy;
    logic                 timeout_err;

    int vectors  = 0;
    int errors   = 0;
    int rr_model = 0;
    int txn      = 0;

    mult_arbiter #(
        .NUM_REQ        (N),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_a       (req_a),
        .req_b       (req_b),
        .grant       (grant),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .mult_a      (mult_a),
        .mult_b      (mult_b),
        .mult_start  (mult_start),
        .mult_out    (mult_out),
        .mult_done   (mult_done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: nearest pending requester at or after the pointer.
    function automatic int model_pick();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (rr_model + k) % N;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        mult_done = 1'b0;
        mult_out  = '0;
        req_a     = '0;
        req_b     = '0;
        tick();
        tick();
        check_eq("rst_grant",       grant,       '0);
        check_eq("rst_resp_valid",  resp_valid,  '0);
        check_eq("rst_resp_data",   resp_data,   '0);
        check_eq("rst_mult_a",      mult_a,      '0);
        check_eq("rst_mult_b",      mult_b,      '0);
        check_eq("rst_mult_start",  mult_start,  1'b0);
        check_eq("rst_busy",        busy,        1'b0);
        check_eq("rst_timeout_err", timeout_err, 1'b0);
        rst      = 1'b0;
        rr_model = 0;
    endtask

    // One full operation; must be called with the DUT in IDLE and req non-zero.
    task automatic serve(input int delay, input bit drop, input bit use_val, input logic [DW-1:0] val);
        int            win;
        logic [DW-1:0] exp_a, exp_b, exp_r;
        win = model_pick();
        check_eq("pending_req", (win >= 0), 1'b1);
        if (win < 0) return;
        exp_a = req_a[win];
        exp_b = req_b[win];
        tick();
        check_eq("grant",      grant,      onehot(win));
        check_eq("mult_start", mult_start, 1'b1);
        check_eq("mult_a",     mult_a,     exp_a);
        check_eq("mult_b",     mult_b,     exp_b);
        check_eq("busy_issue", busy,       1'b1);
        if (drop) req[win] = 1'b0;
        tick();
        check_eq("grant_wait", grant,      '0);
        check_eq("start_once", mult_start, 1'b0);
        for (int d = 0; d < delay; d++) begin
            tick();
            check_eq("grant_hold", grant,      '0);
            check_eq("resp_early", resp_valid, '0);
        end
        mult_done = 1'b1;
        mult_out  = use_val ? val : DW'(exp_a * exp_b);
        exp_r     = mult_out;
        tick();
        mult_done = 1'b0;
        mult_out  = $urandom;
        check_eq("resp_valid",  resp_valid, onehot(win));
        check_eq("resp_data",   resp_data,  exp_r);
        check_eq("grant_resp",  grant,      '0);
        check_eq("mult_a_held", mult_a,     exp_a);
        rr_model = (win + 1) % N;
        tick();
        check_eq("resp_pulse", resp_valid, '0);
        check_eq("busy_idle",  busy,       1'b0);
        check_eq("resp_hold",  resp_data,  exp_r);
        $display("txn %0d: owner=%0d a=%08h b=%08h resp=%08h", txn, win, exp_a, exp_b, exp_r);
        txn++;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst       = 1'b1;
        req       = '0;
        req_a     = '0;
        req_b     = '0;
        mult_done = 1'b0;
        mult_out  = '0;
        do_reset();

        // Single request, 3 * 5
        req_a[0] = 32'd3;
        req_b[0] = 32'd5;
        req      = 2'b01;
        serve(3, 1'b1, 1'b0, '0);

        // Contention from reset, then requester 0 re-raises while 1 still waits
        do_reset();
        req_a[0] = 32'd11; req_b[0] = 32'd12;
        req_a[1] = 32'd21; req_b[1] = 32'd22;
        req      = 2'b11;
        serve(1, 1'b1, 1'b0, '0);
        req_a[0] = 32'd13; req_b[0] = 32'd14;
        req[0]   = 1'b1;
        serve(2, 1'b1, 1'b0, '0);
        serve(0, 1'b1, 1'b0, '0);

        // Persistent request on requester 1
        req      = 2'b10;
        req_a[1] = 32'h1234;
        req_b[1] = 32'h10;
        for (int r = 0; r < 4; r++) serve(2, 1'b0, 1'b0, '0);
        req = '0;
        tick();
        check_eq("idle_no_grant", grant, '0);
        check_eq("idle_not_busy", busy,  1'b0);

        // Reset while waiting on the multiplier, then a stray done
        req_a[0] = 32'd6; req_b[0] = 32'd7;
        req      = 2'b01;
        tick();
        check_eq("pre_rst_grant", grant, 2'b01);
        req = '0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check_eq("rst_wait_busy",  busy,       1'b0);
        check_eq("rst_wait_grant", grant,      '0);
        tick();
        rst       = 1'b0;
        rr_model  = 0;
        mult_done = 1'b1;
        mult_out  = 32'd42;
        tick();
        mult_done = 1'b0;
        check_eq("stray_done_resp", resp_valid, '0);
        check_eq("stray_done_busy", busy,       1'b0);
        check_eq("stray_done_data", resp_data,  '0);
        tick();
        check_eq("stray_done_resp2", resp_valid, '0);
        req_a[0] = 32'd9; req_b[0] = 32'd9;
        req      = 2'b01;
        serve(1, 1'b1, 1'b0, '0);

        // Randomized traffic with held requests
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(1) == 1) begin
                    req[i]   = 1'b1;
                    req_a[i] = $urandom;
                    req_b[i] = $urandom;
                end
            end
            if (req == '0) begin
                int i;
                i        = $urandom_range(N - 1);
                req[i]   = 1'b1;
                req_a[i] = $urandom;
                req_b[i] = $urandom;
            end
            serve($urandom_range(5), 1'b1, 1'b0, '0);
        end

        // Multiplier never answers
        do_reset();
        req_a[0] = 32'd2; req_b[0] = 32'd3;
        req      = 2'b01;
        tick();
        check_eq("to_grant", grant, 2'b01);
        req = '0;
        tick();
`ifdef MULT_ARB_TIMEOUT_EN
        for (int c = 1; c < TO; c++) begin
            tick();
            check_eq("to_no_resp", resp_valid,  '0);
            check_eq("to_err_low", timeout_err, 1'b0);
        end
        tick();
        check_eq("to_resp_valid", resp_valid,  2'b01);
        check_eq("to_resp_data",  resp_data,   '0);
        check_eq("to_err_set",    timeout_err, 1'b1);
        rr_model = 1;
        tick();
        check_eq("to_idle",       busy,        1'b0);
        check_eq("to_err_sticky", timeout_err, 1'b1);
        req_a[1] = 32'd4; req_b[1] = 32'd5;
        req      = 2'b10;
        serve(1, 1'b1, 1'b0, '0);
        check_eq("to_err_sticky2", timeout_err, 1'b1);
        do_reset();
`else
        for (int c = 0; c < 20; c++) begin
            tick();
            check_eq("nto_busy",    busy,        1'b1);
            check_eq("nto_no_resp", resp_valid,  '0);
            check_eq("nto_err_low", timeout_err, 1'b0);
        end
        mult_done = 1'b1;
        mult_out  = 32'd7;
        tick();
        mult_done = 1'b0;
        check_eq("nto_resp_valid", resp_valid, 2'b01);
        check_eq("nto_resp_data",  resp_data,  32'd7);
        rr_model = 1;
        tick();
        check_eq("nto_idle", busy, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
